// File: rtl/gb_alu_pkg.sv
// gb_alu_pkg -- shared types, parameter limits and the 4-bit CLA slice
// used by the pipelined add/sub ALU.
//   flags_t : result flag bundle {z, sub, hc, c}
//   cla4()  : 4-bit carry-lookahead slice, returns {carry_out, sum[3:0]}
package gb_alu_pkg;

  localparam int WIDTH_MIN  = 8;
  localparam int WIDTH_MAX  = 64;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;
  localparam int SLICE_W    = 4;

  typedef struct packed {
    logic z;
    logic sub;
    logic hc;
    logic c;
  } flags_t;

  // Flat two-level lookahead: every carry is a function of g/p and ci only.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

endpackage

// File: rtl/gb_alu_cla_seg.sv
// gb_alu_cla_seg -- combinational SEG_W-bit adder segment built from 4-bit
// CLA slices.
//   a, b : segment operands (b already conditioned for subtract)
//   ci   : carry into the segment
//   s    : segment sum
//   co   : carry out of the segment
//   c4   : carry out of the lowest 4-bit slice (half carry source)
module gb_alu_cla_seg
  import gb_alu_pkg::*;
#(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             c4
);

  localparam int NSL = SEG_W / SLICE_W;

  logic [NSL:0] carry;

  assign carry[0] = ci;

  genvar gi;
  generate
    for (gi = 0; gi < NSL; gi++) begin : g_slice
      logic [4:0] slice_res;
      assign slice_res                = cla4(a[gi*SLICE_W +: SLICE_W], b[gi*SLICE_W +: SLICE_W], carry[gi]);
      assign s[gi*SLICE_W +: SLICE_W] = slice_res[3:0];
      assign carry[gi+1]              = slice_res[4];
    end
  endgenerate

  assign co = carry[NSL];
  assign c4 = carry[1];

endmodule

// File: rtl/gb_alu_addsub_pipe.sv
// gb_alu_addsub_pipe -- pipelined WIDTH-bit add/subtract with valid/ready
// handshake on both sides. Stage k adds operand segment k; the segment carry
// and the untouched upper operand bits travel with the beat to stage k+1.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_valid, o_ready  : input handshake
//   i_a, i_b, i_c     : operands and carry/borrow in
//   i_sub             : 0 = a+b+c, 1 = a-b-c
//   o_valid, i_ready  : output handshake
//   o_s               : result (mod 2^WIDTH)
//   o_c, o_hc         : carry/borrow out of MSB and of bit 3
//   o_z, o_v          : zero and signed overflow
module gb_alu_addsub_pipe
  import gb_alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_c,
  output logic             o_hc,
  output logic             o_z,
  output logic             o_v
);

  localparam int SEG_W = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || (WIDTH % SLICE_W) != 0 ||
        STAGES < STAGES_MIN || STAGES > STAGES_MAX || (WIDTH % STAGES) != 0 ||
        ((WIDTH / STAGES) % SLICE_W) != 0) begin : g_bad_params
      $error("gb_alu_addsub_pipe: illegal WIDTH/STAGES combination");
    end
  endgenerate

  // Per-stage registers; b_reg holds b' (already inverted in sub mode), carries are raw.
  logic [STAGES-1:0]            valid_reg, c_reg, hc_reg, sub_reg;
  logic [STAGES-1:0][WIDTH-1:0] a_reg, b_reg, s_reg;

  // Per-stage inputs (from ports or previous stage) and computed next values.
  logic [STAGES-1:0]            vld_in, cin, hc_in, sub_in, c_next, hc_next, c4;
  logic [STAGES-1:0]            load, unload;
  logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in, s_next;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [SEG_W-1:0] seg_s;
      logic [WIDTH-1:0] sum_merge;

      if (gi == 0) begin : g_head
        // Subtract as a + ~b + ~c so the adder never changes.
        assign vld_in[gi] = i_valid;
        assign a_in[gi]   = i_a;
        assign b_in[gi]   = i_sub ? ~i_b : i_b;
        assign cin[gi]    = i_c ^ i_sub;
        assign s_in[gi]   = '0;
        assign hc_in[gi]  = 1'b0;
        assign sub_in[gi] = i_sub;
      end else begin : g_body
        assign vld_in[gi] = valid_reg[gi-1];
        assign a_in[gi]   = a_reg[gi-1];
        assign b_in[gi]   = b_reg[gi-1];
        assign cin[gi]    = c_reg[gi-1];
        assign s_in[gi]   = s_reg[gi-1];
        assign hc_in[gi]  = hc_reg[gi-1];
        assign sub_in[gi] = sub_reg[gi-1];
      end

      // A stage empties when its beat moves on; it loads when empty or emptying.
      if (gi == LAST) begin : g_tail
        assign unload[gi] = valid_reg[gi] & i_ready;
      end else begin : g_mid
        assign unload[gi] = valid_reg[gi] & load[gi+1];
      end
      assign load[gi] = ~valid_reg[gi] | unload[gi];

      gb_alu_cla_seg #(
        .SEG_W(SEG_W)
      ) u_seg (
        .a (a_in[gi][gi*SEG_W +: SEG_W]),
        .b (b_in[gi][gi*SEG_W +: SEG_W]),
        .ci(cin[gi]),
        .s (seg_s),
        .co(c_next[gi]),
        .c4(c4[gi])
      );

      always_comb begin
        sum_merge                     = s_in[gi];
        sum_merge[gi*SEG_W +: SEG_W]  = seg_s;
      end
      assign s_next[gi] = sum_merge;

      // Bit 3 always lives in segment 0; later stages just forward it.
      assign hc_next[gi] = (gi == 0) ? c4[gi] : hc_in[gi];
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_reg <= '0;
      c_reg     <= '0;
      hc_reg    <= '0;
      sub_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          valid_reg[k] <= vld_in[k];
          if (vld_in[k]) begin
            a_reg[k]   <= a_in[k];
            b_reg[k]   <= b_in[k];
            s_reg[k]   <= s_next[k];
            c_reg[k]   <= c_next[k];
            hc_reg[k]  <= hc_next[k];
            sub_reg[k] <= sub_in[k];
          end
        end
      end
    end
  end

  // Borrow semantics in sub mode: report inverted raw carries.
  flags_t flags;
  assign flags = '{z:   ~|s_reg[LAST],
                   sub: sub_reg[LAST],
                   hc:  hc_reg[LAST] ^ sub_reg[LAST],
                   c:   c_reg[LAST] ^ sub_reg[LAST]};

  assign o_ready = load[0];
  assign o_valid = valid_reg[LAST];
  assign o_s     = s_reg[LAST];
  assign o_c     = flags.c;
  assign o_hc    = flags.hc;
  assign o_z     = flags.z;
  assign o_v     = (a_reg[LAST][WIDTH-1] == b_reg[LAST][WIDTH-1]) &
                   (s_reg[LAST][WIDTH-1] != a_reg[LAST][WIDTH-1]);

  // Operand bits below the active segment and unused slice carries are dead by design.
  logic unused_bits;
  assign unused_bits = ^{a_reg, b_reg, s_reg, hc_in, c4, flags.sub};

endmodule

// File: doc/gb_alu_addsub_pipe.md
GB_ALU_ADDSUB_PIPE -- requirements
Module: gb_alu_addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand width; SHALL be a multiple of 4 in range 8..64.
REQ-002 Parameter STAGES, default 2, pipeline depth; SHALL be 1..4, and WIDTH/STAGES SHALL be a multiple of 4.
REQ-003 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 i_valid  in  1  operand beat present.
REQ-006 o_ready  out  1  block accepts a beat this cycle.
REQ-007 i_a, i_b  in  WIDTH  operands.
REQ-008 i_c  in  1  carry-in for add; borrow-in for sub.
REQ-009 i_sub  in  1  0 = a+b+c; 1 = a-b-c.
REQ-010 o_valid  out  1  result beat present.
REQ-011 i_ready  in  1  downstream accepts result.
REQ-012 o_s  out  WIDTH  sum/difference.
REQ-013 o_c  out  1  carry-out (add) or borrow-out (sub).
REQ-014 o_hc  out  1  half carry/borrow out of bit 3.
REQ-015 o_z  out  1  o_s == 0.
REQ-016 o_v  out  1  signed two's-complement overflow.

Function
REQ-017 Transfer in occurs on i_valid & o_ready; transfer out occurs on o_valid & i_ready.
REQ-018 Operand split into STAGES equal segments; segment k SHALL be computed by carry-lookahead in stage k, with its carry registered into stage k+1 together with the not-yet-used upper operand bits.
REQ-019 Sub mode SHALL compute a + ~b + ~i_c; o_c and o_hc SHALL be the inverted raw carries (borrow semantics).
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to o_valid, absent backpressure.
REQ-021 Each stage SHALL hold a valid bit; a stage loads when it is empty or the stage after it unloads in the same cycle.
REQ-022 o_ready SHALL be !valid[0] | advance[0], combinationally; full throughput is one beat per cycle when i_ready=1.
REQ-023 With i_ready=0, the pipeline SHALL fill to STAGES beats, then drop o_ready; no beat SHALL be lost or duplicated.
REQ-024 Simultaneous input and output transfer on a full pipeline SHALL shift all stages by one and keep occupancy unchanged.
REQ-025 o_s, o_c, o_hc, o_z, o_v SHALL be stable while o_valid=1 and i_ready=0.
REQ-026 o_z and o_v SHALL be computed from the final registered result; o_v = (a[MSB]==b'[MSB]) & (s[MSB]!=a[MSB]), where b' is b in add mode and ~b in sub mode.
REQ-027 Data outputs are don't-care while o_valid=0.
REQ-028 Wrap-around: the result is taken modulo 2^WIDTH; the overflow bit goes only to o_c.

Reset
REQ-029 i_rst SHALL asynchronously clear all stage valid bits, forcing o_valid=0 and o_ready=1.
REQ-030 While i_rst=1, reset SHALL clear o_s to 0 and o_c, o_hc, o_v to 0; o_z follows REQ-015.
REQ-031 Reset mid-operation SHALL discard all in-flight beats; the first beat accepted after release SHALL emerge after STAGES cycles.

Structure
REQ-032 Package gb_alu_pkg SHALL hold the flag struct {z, sub, hc, c} and constants for the WIDTH/STAGES limits.
REQ-033 One sub-module gb_alu_cla_seg (parametrised segment CLA, built from the existing 4-bit CLA slices) SHALL be instantiated once per stage.
REQ-034 Legality checks on WIDTH/STAGES SHALL be made at elaboration.

Verification (WIDTH=16, STAGES=2 unless stated)
REQ-035 Add a=0x00FF, b=0x0001, c=0 -> after 2 cycles s=0x0100, c=0, hc=1, z=0, v=0.
REQ-036 Sub a=0x0000, b=0x0001, c=0 -> s=0xFFFF, c=1, hc=1, z=0, v=0; add a=0x7FFF, b=0x0001 -> s=0x8000, v=1.
REQ-037 Back-to-back stream of 8 beats with i_ready toggling randomly -> results in order, none lost; o_ready=0 only when 2 beats are held and i_ready=0.
REQ-038 Add a=0xFFFF, b=0x0000, c=1 -> s=0x0000, c=1, z=1, hc=1 (wrap-around).
REQ-039 Assert i_rst with 2 beats in flight -> o_valid=0 immediately, o_ready=1; the next beat is accepted and valid 2 cycles later.
REQ-040 WIDTH=32, STAGES=4, and WIDTH=8, STAGES=1: 1000 random add/sub beats -> match a reference model bit-exactly, latency equal to STAGES.
